dualrail_chan_arbiter: RTL and testbench

Clocked arbiter that merges two four-phase dual-rail (1-of-2) input channels, A and B, onto one shared dual-rail output channel R. It acts as the receiver on both input channels and as the sender on R, with an enable that is high when the receiver is ready. It sits between prsim-driven channel sources and a shared downstream sink in co-simulation benches. It records which source won each transfer, and it flags protocol errors and stalls.

---
 rtl/dualrail_chan_arbiter.sv | 103 ++++++++++
 tb/tb_dualrail_chan_arbiter.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/dualrail_chan_arbiter.sv
// dualrail_chan_arbiter: merges two four-phase dual-rail input channels onto one shared output channel
module dualrail_chan_arbiter #(
  parameter int SYNC_STAGES = 2,
  parameter int TIMEOUT = 1024,
  parameter int TW = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic a0,
  input  logic a1,
  output logic ae,
  input  logic b0,
  input  logic b1,
  output logic be,
  output logic r0,
  output logic r1,
  input  logic re,
  output logic src,
  output logic err,
  output logic tmo
);
  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] WAITR  = 3'd1;
  localparam logic [2:0] SEND   = 3'd2;
  localparam logic [2:0] INRTZ  = 3'd3;
  localparam logic [2:0] OUTRTZ = 3'd4;
  localparam logic [TW-1:0] TLIM = TW'(TIMEOUT);
  localparam bit WD_EN = TIMEOUT != 0;
  logic [SYNC_STAGES-1:0][4:0] sync;
  logic a0_s, a1_s, b0_s, b1_s, re_s;
  logic a_v, b_v, a_il, b_il, gnt_b, w_neu, adv;
  logic [2:0] state;
  logic pri, dat;
  logic [TW-1:0] cnt;
  always_ff @(posedge clk or posedge reset)
    if (reset) sync <= '0;
    else begin
      sync[0] <= {re, b1, b0, a1, a0};
      for (int i = 1; i < SYNC_STAGES; i++) sync[i] <= sync[i-1];
    end
  assign {re_s, b1_s, b0_s, a1_s, a0_s} = sync[SYNC_STAGES-1];
  always_comb begin
    a_v   = a0_s ^ a1_s;
    b_v   = b0_s ^ b1_s;
    a_il  = a0_s & a1_s;
    b_il  = b0_s & b1_s;
    gnt_b = b_v & (~a_v | pri);
    w_neu = src ? ~(b0_s | b1_s) : ~(a0_s | a1_s);
    adv   = state == IDLE  ? (a_v | b_v) :
            state == WAITR ? re_s :
            state == SEND  ? ~re_s :
            state == INRTZ ? w_neu : re_s;
  end
  // The watchdog counter restarts on every state change and saturates at the limit.
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state <= IDLE;
      ae    <= 1'b1;
      be    <= 1'b1;
      r0    <= 1'b0;
      r1    <= 1'b0;
      src   <= 1'b0;
      err   <= 1'b0;
      tmo   <= 1'b0;
      pri   <= 1'b0;
      dat   <= 1'b0;
      cnt   <= '0;
    end else begin
      err <= err | a_il | b_il;
      tmo <= tmo | (WD_EN && cnt == TLIM);
      if (adv) begin
        cnt <= '0;
        case (state)
          IDLE: begin
            src   <= gnt_b;
            dat   <= gnt_b ? b1_s : a1_s;
            state <= WAITR;
          end
          WAITR: begin
            r0    <= ~dat;
            r1    <= dat;
            state <= SEND;
          end
          SEND: begin
            ae    <= ae & src;
            be    <= be & ~src;
            state <= INRTZ;
          end
          INRTZ: begin
            r0    <= 1'b0;
            r1    <= 1'b0;
            state <= OUTRTZ;
          end
          default: begin
            ae    <= 1'b1;
            be    <= 1'b1;
            pri   <= ~src;
            state <= IDLE;
          end
        endcase
      end else if (state != IDLE && cnt != TLIM) cnt <= cnt + TW'(1);
    end
endmodule

// File: tb/tb_dualrail_chan_arbiter.sv
// tb_dualrail_chan_arbiter: scoreboard bench for the dual-rail channel arbiter
module tb_dualrail_chan_arbiter;
  logic clk = 0, reset = 1;
  logic a0 = 0, a1 = 0, b0 = 0, b1 = 0, re = 1;
  logic ae, be, r0, r1, src, err, tmo;
  int errors = 0, checks = 0;
  bit sink_on = 1;
  bit [1:0] exp_q[$];
  logic pr = 0;

  always #5 clk = ~clk;

  dualrail_chan_arbiter #(.SYNC_STAGES(2), .TIMEOUT(8), .TW(8)) dut (
    .clk(clk), .reset(reset), .a0(a0), .a1(a1), .ae(ae), .b0(b0), .b1(b1), .be(be),
    .r0(r0), .r1(r1), .re(re), .src(src), .err(err), .tmo(tmo)
  );

  task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s: got %0h want %0h at %0t", nm, act, want, $time);
    end
  endtask

  function automatic logic sig(input int w);
    return w == 0 ? ae : w == 1 ? be : (r0 | r1);
  endfunction

  task automatic wait_for(input int w, input logic v, input string nm);
    int n = 0;
    while (sig(w) !== v && n < 300) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (n >= 300) begin
      errors++;
      $display("FAIL %s: timed out waiting for %0b", nm, v);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1;
    @(negedge clk);
    reset = 0;
  endtask

  task automatic run_src(input bit s, input bit d[16]);
    for (int i = 0; i < 16; i++) begin
      wait_for(s, 1, "src_en_high");
      if (s) begin b0 = !d[i]; b1 = d[i]; end
      else begin a0 = !d[i]; a1 = d[i]; end
      wait_for(s, 0, "src_en_low");
      repeat ($urandom_range(0, 3)) @(negedge clk);
      if (s) begin b0 = 0; b1 = 0; end
      else begin a0 = 0; a1 = 0; end
      @(negedge clk);
    end
  endtask

  // Monitor: invariants every cycle, and each rising output token is matched against the scoreboard.
  always @(negedge clk) begin
    bit [1:0] t;
    chk("r_both_high", r0 & r1, 0);
    chk("both_en_low", ae | be, 1);
    if ((r0 | r1) && !pr) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_token: got src=%0b r1=%0b want none", src, r1);
      end else begin
        t = exp_q.pop_front();
        chk("tok_src", src, t[1]);
        chk("tok_r1", r1, t[0]);
        chk("tok_r0", r0, !t[0]);
      end
    end
    pr = r0 | r1;
  end

  // Sink: acknowledges data and neutral with a random delay.
  always begin
    @(negedge clk);
    if (sink_on && !reset) begin
      if (re && (r0 | r1)) begin
        repeat ($urandom_range(0, 3)) @(negedge clk);
        if (sink_on) re = 0;
      end else if (!re && !(r0 | r1)) begin
        repeat ($urandom_range(0, 3)) @(negedge clk);
        if (sink_on) re = 1;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL global_timeout");
    $fatal(1, "bench timeout");
  end

  initial begin
    bit da[16], db[16];
    bit p;
    int ia, ib;
    repeat (3) @(negedge clk);
    chk("rst_ae", ae, 1); chk("rst_be", be, 1); chk("rst_r0", r0, 0); chk("rst_r1", r1, 0);
    chk("rst_src", src, 0); chk("rst_err", err, 0); chk("rst_tmo", tmo, 0);
    reset = 0;
    // single A token
    @(negedge clk);
    exp_q.push_back(2'b01);
    a1 = 1;
    wait_for(0, 0, "t1_ae_low");
    chk("t1_r1", r1, 1); chk("t1_src", src, 0); chk("t1_be", be, 1);
    a1 = 0;
    wait_for(2, 0, "t1_rtz");
    chk("t1_ae_still_low", ae, 0);
    wait_for(0, 1, "t1_ae_high");
    chk("t1_be_end", be, 1);
    // contention from reset: A first, then B (pri=1) ahead of a fresh A
    do_reset();
    exp_q.push_back(2'b00); exp_q.push_back(2'b11); exp_q.push_back(2'b01);
    a0 = 1; b1 = 1;
    wait_for(0, 0, "t2_a_low");
    chk("t2_src_a", src, 0);
    a0 = 0;
    wait_for(0, 1, "t2_a_high");
    a1 = 1;
    wait_for(1, 0, "t2_b_low");
    chk("t2_src_b", src, 1); chk("t2_ae_during_b", ae, 1);
    b1 = 0;
    wait_for(1, 1, "t2_b_high");
    wait_for(0, 0, "t2_a2_low");
    chk("t2_src_a2", src, 0);
    a1 = 0;
    wait_for(0, 1, "t2_a2_high");
    // sink stall in WAITR
    sink_on = 0;
    re = 0;
    repeat (4) @(negedge clk);
    exp_q.push_back(2'b00);
    a0 = 1;
    repeat (6) @(negedge clk);
    chk("t3_tmo_early", tmo, 0);
    repeat (10) @(negedge clk);
    chk("t3_tmo", tmo, 1); chk("t3_r0", r0, 0); chk("t3_r1", r1, 0); chk("t3_ae", ae, 1);
    sink_on = 1;
    wait_for(0, 0, "t3_ae_low");
    a0 = 0;
    wait_for(0, 1, "t3_ae_high");
    chk("t3_tmo_sticky", tmo, 1);
    // reset in SEND, pending token re-served
    sink_on = 0;
    exp_q.push_back(2'b10); exp_q.push_back(2'b10);
    b0 = 1;
    wait_for(2, 1, "t4_r_up");
    chk("t4_r0_sent", r0, 1);
    reset = 1;
    #1;
    chk("t4_r0", r0, 0); chk("t4_r1", r1, 0); chk("t4_ae", ae, 1); chk("t4_be", be, 1);
    chk("t4_err", err, 0); chk("t4_tmo", tmo, 0);
    @(negedge clk);
    reset = 0;
    sink_on = 1;
    wait_for(1, 0, "t4_be_low");
    chk("t4_src", src, 1);
    b0 = 0;
    wait_for(1, 1, "t4_be_high");
    // illegal code on A, valid B still served
    @(negedge clk);
    a0 = 1; a1 = 1;
    repeat (2) @(negedge clk);
    chk("t5_err_early", err, 0);
    @(negedge clk);
    chk("t5_err", err, 1);
    exp_q.push_back(2'b11);
    b1 = 1;
    wait_for(1, 0, "t5_be_low");
    chk("t5_ae", ae, 1); chk("t5_src", src, 1);
    b1 = 0;
    wait_for(1, 1, "t5_be_high");
    a0 = 0; a1 = 0;
    chk("t5_err_sticky", err, 1);
    // sustained contention: reference order alternates from pri=0
    do_reset();
    foreach (da[i]) begin da[i] = 1'($urandom); db[i] = 1'($urandom); end
    p = 0; ia = 0; ib = 0;
    repeat (32) begin
      if (!p) exp_q.push_back({1'b0, da[ia++]});
      else exp_q.push_back({1'b1, db[ib++]});
      p = !p;
    end
    fork
      run_src(0, da);
      run_src(1, db);
    join
    wait_for(2, 0, "t6_r_neutral");
    wait_for(0, 1, "t6_ae_high");
    wait_for(1, 1, "t6_be_high");
    chk("t6_queue_empty", 8'(exp_q.size()), 0);
    chk("t6_tmo", tmo, 0);
    chk("t6_err", err, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
